// File: rtl/arb_fifo_frontend.sv
// Four-requester round-robin arbiter feeding a show-ahead FIFO drained by a single consumer.
// Optional sticky protocol/underflow error output enabled by defining ARB_FIFO_ERR_EN.
module arb_fifo_frontend #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      arb_req,
    input  logic [4*DW-1:0] req_data,
    output logic [3:0]      arb_gnt,
    input  logic            fifo_pop,
    output logic [DW-1:0]   data_out,
    output logic            fifo_push,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic [7:0]      fifo_count
`ifdef ARB_FIFO_ERR_EN
    ,
    output logic            err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [1:0]    prio_q, prio_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem [DEPTH];

    logic [1:0]    gnt_idx;
    logic          gnt_vld;
    logic          gnt_ok;
    logic          pop_eff;

    // First asserted request searching from prio upward, wrapping mod 4
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!gnt_vld && arb_req[prio_q + 2'(k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = prio_q + 2'(k);
            end
        end
    end

    // Grant masked by the registered full flag and held low during reset
    assign gnt_ok     = gnt_vld & ~fifo_full & rst_n;
    assign arb_gnt    = gnt_ok ? (4'b0001 << gnt_idx) : 4'b0000;
    assign fifo_push  = gnt_ok;
    assign pop_eff    = fifo_pop & ~fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_count = 8'(count_q);
    assign data_out   = mem[rptr_q];

    always_comb begin
        prio_d  = prio_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (gnt_ok) begin
            prio_d = gnt_idx + 2'd1;
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_eff) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({gnt_ok, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= 2'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            prio_q  <= prio_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (gnt_ok) begin
            mem[wptr_q] <= req_data[gnt_idx*DW +: DW];
        end
    end

`ifdef ARB_FIFO_ERR_EN
    logic [3:0] pend_q;
    logic       err_q, err_d;

    // Sticky: underflow attempt, or a pending request withdrawn before its grant
    always_comb begin
        err_d = err_q | (fifo_pop & fifo_empty) | (|(pend_q & ~arb_req));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0000;
            err_q  <= 1'b0;
        end else begin
            pend_q <= arb_req & ~arb_gnt;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_arb_fifo_frontend.sv
// Directed bench for arb_fifo_frontend: ordering, full/empty boundaries, mid-run reset, fairness.
module tb_arb_fifo_frontend;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic            clk;
    logic            rst_n;
    logic [3:0]      arb_req;
    logic [4*DW-1:0] req_data;
    logic [3:0]      arb_gnt;
    logic            fifo_pop;
    logic [DW-1:0]   data_out;
    logic            fifo_push;
    logic            fifo_empty;
    logic            fifo_full;
    logic [7:0]      fifo_count;
`ifdef ARB_FIFO_ERR_EN
    logic            err;
`endif

    int total = 0;
    int bad   = 0;

    arb_fifo_frontend #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_req   (arb_req),
        .req_data  (req_data),
        .arb_gnt   (arb_gnt),
        .fifo_pop  (fifo_pop),
        .data_out  (data_out),
        .fifo_push (fifo_push),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count)
`ifdef ARB_FIFO_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pend;
        logic [3:0] g;
        int         wt [4];

        rst_n    = 1'b0;
        arb_req  = 4'b1111;
        fifo_pop = 1'b0;
        req_data = '0;
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 32'hA0 + 32'(i);

        // Reset state, grant forced low despite requests
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full",  32'(fifo_full),  32'd0);
        chk("rst_gnt",   32'(arb_gnt),    32'd0);
        chk("rst_push",  32'(fifo_push),  32'd0);

        // Round-robin order from prio 0, each requester drops once granted
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt", 32'(arb_gnt), 32'(1 << i));
            tick();
            chk("rr_count", 32'(fifo_count), 32'(i + 1));
            arb_req[i] = 1'b0;
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            chk("rr_dout", data_out, 32'hA0 + 32'(i));
            fifo_pop = 1'b1;
            tick();
            fifo_pop = 1'b0;
        end
        chk("rr_drained_cnt",   32'(fifo_count), 32'd0);
        chk("rr_drained_empty", 32'(fifo_empty), 32'd1);

        // Single requester fills to DEPTH
        arb_req = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            req_data[2*DW +: DW] = 32'hB000 + 32'(i);
            #1;
            chk("fill_gnt", 32'(arb_gnt), 32'h4);
            tick();
        end
        req_data[2*DW +: DW] = 32'hB010;
        #1;
        chk("full_flag",  32'(fifo_full),  32'd1);
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_gnt",   32'(arb_gnt),    32'd0);
        fifo_pop = 1'b1;
        #1;
        chk("full_pop_gnt", 32'(arb_gnt), 32'd0);
        tick();
        fifo_pop = 1'b0;
        #1;
        chk("after_pop_count", 32'(fifo_count), 32'd15);
        chk("after_pop_full",  32'(fifo_full),  32'd0);
        chk("after_pop_gnt",   32'(arb_gnt),    32'h4);
        chk("after_pop_dout",  data_out,        32'hB001);
        tick();
        arb_req = 4'b0000;
        chk("refull_count", 32'(fifo_count), 32'd16);
        chk("refull_flag",  32'(fifo_full),  32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_dout", data_out, 32'hB001 + 32'(i));
            fifo_pop = 1'b1;
            tick();
        end
        fifo_pop = 1'b0;
        chk("drain_empty", 32'(fifo_empty), 32'd1);
`ifdef ARB_FIFO_ERR_EN
        chk("err_clean", 32'(err), 32'd0);
`endif

        // Pop while empty is ignored
        fifo_pop = 1'b1;
        tick();
        tick();
        fifo_pop = 1'b0;
        chk("uflow_count", 32'(fifo_count), 32'd0);
        chk("uflow_empty", 32'(fifo_empty), 32'd1);
`ifdef ARB_FIFO_ERR_EN
        chk("uflow_err", 32'(err), 32'd1);
`endif

        // Simultaneous push and pop at count 5
        arb_req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            req_data[1*DW +: DW] = 32'hC0 + 32'(i);
            tick();
        end
        chk("c5_count", 32'(fifo_count), 32'd5);
        req_data[1*DW +: DW] = 32'hC5;
        fifo_pop = 1'b1;
        #1;
        chk("c5_gnt",  32'(arb_gnt), 32'h2);
        chk("c5_head", data_out,     32'hC0);
        tick();
        fifo_pop = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd5);
        chk("pp_head",  data_out,        32'hC1);
        req_data[1*DW +: DW] = 32'hC6;
        tick();
        req_data[1*DW +: DW] = 32'hC7;
        tick();
        chk("c7_count", 32'(fifo_count), 32'd7);

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rst_full",  32'(fifo_full),  32'd0);
        chk("mid_rst_gnt",   32'(arb_gnt),    32'd0);
        tick();
        rst_n   = 1'b1;
        arb_req = 4'b1010;
        req_data[1*DW +: DW] = 32'hD1;
        req_data[3*DW +: DW] = 32'hD3;
        #1;
        chk("post_rst_gnt", 32'(arb_gnt), 32'h2);
        tick();
        chk("post_rst_count", 32'(fifo_count), 32'd1);
        chk("post_rst_dout",  data_out,        32'hD1);
        arb_req = 4'b1000;
        #1;
        chk("post_rst_gnt2", 32'(arb_gnt), 32'h8);
        tick();
        arb_req = 4'b0000;
        chk("post_rst_count2", 32'(fifo_count), 32'd2);

        // Fairness sweep: random requests held until granted, consumer always popping
        pend     = 4'b0000;
        fifo_pop = 1'b1;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int c = 0; c < 150; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    wt[i]   = 0;
                end
            end
            arb_req = pend;
            for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = 32'(c * 4 + i);
            #1;
            g = arb_gnt;
            chk("fair_onehot0",  32'($onehot0(g)),          32'd1);
            chk("fair_gnt_req",  32'(g & ~pend),            32'd0);
            chk("fair_gnt_some", 32'((pend != 0) == (g != 0)), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    chk("fair_latency", 32'(wt[i] <= 3), 32'd1);
                    pend[i] = 1'b0;
                end else if (pend[i]) begin
                    wt[i]++;
                    chk("fair_wait", 32'(wt[i] <= 3), 32'd1);
                end
            end
            tick();
        end
        arb_req  = 4'b0000;
        fifo_pop = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
